snitch_vfpr_wr_sched: RTL and testbench

Write-port scheduler for the vector FP register file (VFPR). Shares the VFPR's single TCDM-style write port among `NumReq` writeback sources (e.g. FPU result, LSU load return, SSR stream) using round-robin arbitration. Tracks in-flight writes until the VFPR acknowledges them, and flags read-after-write hazards against the VFPR read-port addresses. Sits between the FPU/LSU writeback paths and the VFPR write request/response port.

---
 rtl/snitch_vfpr_wr_sched.sv | 206 ++++++++++++++++++++
 tb/tb_snitch_vfpr_wr_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_vfpr_wr_sched.sv
// snitch_vfpr_wr_sched
// Shares the single VFPR write port among NumReq writeback sources with a
// round-robin arbiter and a grant lock. Counts accepted-but-unacknowledged
// writes, raises a sticky error on an unexpected acknowledge, and optionally
// flags read-after-write hazards against the VFPR read-port addresses.
// Optional feature macro: SNITCH_VFPR_WR_SCHED_HAZARD_EN compiles in the
// in-flight address FIFO and the hazard comparators; without it hazard_o is 0.
module snitch_vfpr_wr_sched #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 16,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_data_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   req_strb_i,
  output logic                                 wr_q_valid_o,
  input  logic                                 wr_q_ready_i,
  output logic [AddrWidth-1:0]                 wr_addr_o,
  output logic [DataWidth-1:0]                 wr_data_o,
  output logic [DataWidth/8-1:0]               wr_strb_o,
  input  logic                                 wr_p_valid_i,
  input  logic [2:0][AddrWidth-1:0]            chk_addr_i,
  input  logic [2:0]                           chk_en_i,
  output logic [2:0]                           hazard_o,
  output logic                                 idle_o,
  output logic                                 err_o
);

  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;

  typedef logic [IdxWidth-1:0] idx_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam idx_t LastIdx = idx_t'(NumReq - 1);
  localparam cnt_t CntMax  = cnt_t'(MaxOutstanding);

  idx_t rr_q, rr_d;
  idx_t lock_idx_q, lock_idx_d;
  logic lock_q, lock_d;
  cnt_t cnt_q, cnt_d;
  logic err_q, err_d;

  idx_t gnt_idx;
  logic any_valid;
  logic full;
  logic handshake;
  logic ack_pop;
  logic ack_err;

  assign any_valid    = |req_valid_i;
  // full comes straight from the registered count, so an ack in the same
  // cycle cannot reopen the port; issue resumes one cycle later.
  assign full         = (cnt_q == CntMax);
  assign wr_q_valid_o = any_valid & ~full;
  assign handshake    = wr_q_valid_o & wr_q_ready_i;
  assign ack_pop      = wr_p_valid_i & (cnt_q != '0);
  assign ack_err      = wr_p_valid_i & (cnt_q == '0);

  // Pick the first valid requester at or after rr_q; a held grant overrides
  always_comb begin
    int unsigned cand;
    idx_t        cand_idx;
    logic        found;
    gnt_idx  = rr_q;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    if (lock_q) begin
      gnt_idx = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = 32'(rr_q) + k;
        if (cand >= NumReq) begin
          cand = cand - NumReq;
        end
        cand_idx = idx_t'(cand);
        if (!found && req_valid_i[cand_idx]) begin
          gnt_idx = cand_idx;
          found   = 1'b1;
        end
      end
    end
  end

  assign wr_addr_o = req_addr_i[gnt_idx];
  assign wr_data_o = req_data_i[gnt_idx];
  assign wr_strb_o = req_strb_i[gnt_idx];

  // Only the granted requester sees the downstream ready (gated by full)
  always_comb begin
    req_ready_o          = '0;
    req_ready_o[gnt_idx] = wr_q_ready_i & ~full;
  end

  // Rotate priority and drop the lock on handshake; hold the grant otherwise
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q | ack_err;
    if (handshake) begin
      rr_d   = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
      lock_d = 1'b0;
    end else if (wr_q_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    case ({handshake, ack_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Arbitration, outstanding count and sticky error state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o  = err_q;
  assign idle_o = ~any_valid & (cnt_q == '0);

`ifdef SNITCH_VFPR_WR_SCHED_HAZARD_EN
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  typedef logic [PtrWidth-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(MaxOutstanding - 1);

  logic [AddrWidth-1:0]      fifo_q [MaxOutstanding];
  logic [AddrWidth-1:0]      fifo_d [MaxOutstanding];
  logic [MaxOutstanding-1:0] vld_q, vld_d;
  ptr_t                      wr_ptr_q, wr_ptr_d;
  ptr_t                      rd_ptr_q, rd_ptr_d;

  // Retire the oldest address on ack, then append the granted address;
  // pop and push never collide on one slot because a pop needs cnt>0 and
  // a push needs cnt<MaxOutstanding.
  always_comb begin
    fifo_d   = fifo_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ack_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    if (handshake) begin
      fifo_d[wr_ptr_q] = wr_addr_o;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  // In-flight address storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < MaxOutstanding; e++) begin
        fifo_q[e] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fifo_q   <= fifo_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A read port is hazardous if its address is still in flight or is the
  // write being offered to the VFPR this cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_hazard
    logic [MaxOutstanding-1:0] entry_hit;
    for (genvar gj = 0; gj < MaxOutstanding; gj++) begin : g_entry
      assign entry_hit[gj] = vld_q[gj] & (fifo_q[gj] == chk_addr_i[gi]);
    end
    assign hazard_o[gi] = chk_en_i[gi] &
                          ((|entry_hit) | (wr_q_valid_o & (wr_addr_o == chk_addr_i[gi])));
  end
`else
  // Hazard tracking compiled out: only the outstanding count remains.
  logic unused_chk;
  assign unused_chk = ^{chk_addr_i, chk_en_i};
  assign hazard_o   = 3'b000;
`endif

endmodule

// File: tb/tb_snitch_vfpr_wr_sched.sv
// Self-checking bench for snitch_vfpr_wr_sched (NumReq=2, MaxOutstanding=4).
// Directed scenario tasks plus a randomized run against a queue-based model.
module tb_snitch_vfpr_wr_sched;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MO = 4;

`ifdef SNITCH_VFPR_WR_SCHED_HAZARD_EN
  localparam bit HzEn = 1'b1;
`else
  localparam bit HzEn = 1'b0;
`endif

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [N-1:0]             req_valid_i;
  logic [N-1:0]             req_ready_o;
  logic [N-1:0][AW-1:0]     req_addr_i;
  logic [N-1:0][DW-1:0]     req_data_i;
  logic [N-1:0][SW-1:0]     req_strb_i;
  logic                     wr_q_valid_o;
  logic                     wr_q_ready_i;
  logic [AW-1:0]            wr_addr_o;
  logic [DW-1:0]            wr_data_o;
  logic [SW-1:0]            wr_strb_o;
  logic                     wr_p_valid_i;
  logic [2:0][AW-1:0]       chk_addr_i;
  logic [2:0]               chk_en_i;
  logic [2:0]               hazard_o;
  logic                     idle_o;
  logic                     err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: in-flight addresses in acceptance order
  logic [AW-1:0] m_q[$];
  int            m_start;
  bit            m_lock;
  int            m_lock_g;
  bit            m_err;

  // Model expectations for the current cycle
  bit            e_valid;
  int            e_g;
  logic [N-1:0]  e_ready;
  logic [2:0]    e_hz;
  bit            e_idle;

  snitch_vfpr_wr_sched #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_strb_i(req_strb_i),
    .wr_q_valid_o(wr_q_valid_o), .wr_q_ready_i(wr_q_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .wr_p_valid_i(wr_p_valid_i),
    .chk_addr_i(chk_addr_i), .chk_en_i(chk_en_i), .hazard_o(hazard_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Expected outputs from the arbitration and tracking rules
  function automatic void model_eval();
    bit any  = |req_valid_i;
    bit full = (m_q.size() == MO);
    e_g = m_start;
    if (m_lock) begin
      e_g = m_lock_g;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        int j = (m_start + k) % N;
        if (req_valid_i[j]) e_g = j;
      end
    end
    e_valid = any && !full;
    e_ready = '0;
    if (wr_q_ready_i && !full) e_ready[e_g] = 1'b1;
    e_idle = !any && (m_q.size() == 0);
    e_hz   = '0;
    if (HzEn) begin
      for (int i = 0; i < 3; i++) begin
        bit hit = 1'b0;
        foreach (m_q[q]) if (m_q[q] == chk_addr_i[i]) hit = 1'b1;
        if (e_valid && req_addr_i[e_g] == chk_addr_i[i]) hit = 1'b1;
        e_hz[i] = chk_en_i[i] & hit;
      end
    end
  endfunction

  // Advance the model across one clock edge using the current inputs
  function automatic void model_commit();
    bit hs = e_valid && wr_q_ready_i;
    if (wr_p_valid_i) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else void'(m_q.pop_front());
    end
    if (hs) begin
      m_q.push_back(req_addr_i[e_g]);
      m_start = (e_g + 1) % N;
      m_lock  = 1'b0;
    end else if (e_valid) begin
      m_lock   = 1'b1;
      m_lock_g = e_g;
    end
  endfunction

  task automatic clear_inputs();
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_data_i   = '0;
    req_strb_i   = '0;
    wr_q_ready_i = 1'b0;
    wr_p_valid_i = 1'b0;
    chk_addr_i   = '0;
    chk_en_i     = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    clear_inputs();
    m_q.delete();
    m_start = 0; m_lock = 1'b0; m_lock_g = 0; m_err = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic cyc_start();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (hazard_o !== 3'b000) begin n_bad++; $display("FAIL reset_hazard: got %b want 000", hazard_o); end
    n_cmp++; if (wr_q_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid_idle: got %b want 0", wr_q_valid_o); end
    req_valid_i = 2'b10; req_addr_i[1] = 16'h0BEE;
    #1;
    n_cmp++; if (wr_q_valid_o !== 1'b1) begin n_bad++; $display("FAIL reset_valid_follow: got %b want 1", wr_q_valid_o); end
    n_cmp++; if (wr_addr_o !== 16'h0BEE) begin n_bad++; $display("FAIL reset_addr_follow: got %h want 0bee", wr_addr_o); end
    n_cmp++; if (idle_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", idle_o); end
    $display("reset: checked idle/err/hazard and combinational issue under reset");
  endtask

  task automatic test_fairness();
    bit   ack_nxt = 1'b0;
    int   cnt_g0 = 0;
    int   cnt_g1 = 0;
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int j = 0; j < N; j++) begin
      req_addr_i[j] = {8'(j), 8'($urandom)};
      req_data_i[j] = {$urandom, $urandom};
      req_strb_i[j] = 8'($urandom);
    end
    for (int k = 0; k < 16; k++) begin
      cyc_start();
      if (k > 0) begin
        req_addr_i[(k - 1) % 2] = {8'((k - 1) % 2), 8'($urandom)};
        req_data_i[(k - 1) % 2] = {$urandom, $urandom};
      end
      req_valid_i  = 2'b11;
      wr_q_ready_i = 1'b1;
      wr_p_valid_i = ack_nxt;
      #4;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (req_ready_o !== exp_rdy) begin n_bad++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready_o, exp_rdy); end
      n_cmp++; if (wr_addr_o !== req_addr_i[k % 2]) begin n_bad++; $display("FAIL fair_addr[%0d]: got %h want %h", k, wr_addr_o, req_addr_i[k % 2]); end
      if (req_ready_o[0]) cnt_g0++;
      if (req_ready_o[1]) cnt_g1++;
      $display("fair write %0d: ready=%b addr=%h", k, req_ready_o, wr_addr_o);
      ack_nxt = wr_q_valid_o;
    end
    cyc_start();
    req_valid_i = '0; wr_q_ready_i = 1'b0; wr_p_valid_i = ack_nxt;
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (cnt_g0 != 8 || cnt_g1 != 8) begin n_bad++; $display("FAIL fair_count: got %0d/%0d want 8/8", cnt_g0, cnt_g1); end
    n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL fair_idle: got %b want 1", idle_o); end
  endtask

  task automatic test_grant_lock();
    do_reset();
    // One write from req0 moves the priority pointer to req1
    cyc_start();
    req_valid_i = 2'b01; req_addr_i[0] = 16'h1111; wr_q_ready_i = 1'b1;
    #4;
    n_cmp++; if (wr_addr_o !== 16'h1111) begin n_bad++; $display("FAIL lock_pre: got %h want 1111", wr_addr_o); end
    for (int c = 0; c < 3; c++) begin
      cyc_start();
      req_addr_i[0] = 16'h00A0; wr_q_ready_i = 1'b0;
      wr_p_valid_i  = (c == 0);
      if (c >= 1) begin req_valid_i = 2'b11; req_addr_i[1] = 16'h00B1; end
      #4;
      n_cmp++; if (wr_addr_o !== 16'h00A0) begin n_bad++; $display("FAIL lock_hold[%0d]: got %h want 00a0", c, wr_addr_o); end
      n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL lock_ready[%0d]: got %b want 00", c, req_ready_o); end
    end
    cyc_start();
    wr_q_ready_i = 1'b1; wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (req_ready_o !== 2'b01 || wr_addr_o !== 16'h00A0) begin n_bad++; $display("FAIL lock_accept: got %b/%h want 01/00a0", req_ready_o, wr_addr_o); end
    $display("lock: req0 accepted addr %h", wr_addr_o);
    cyc_start();
    req_valid_i = 2'b10;
    #4;
    n_cmp++; if (req_ready_o !== 2'b10 || wr_addr_o !== 16'h00B1) begin n_bad++; $display("FAIL lock_next: got %b/%h want 10/00b1", req_ready_o, wr_addr_o); end
    $display("lock: req1 accepted addr %h", wr_addr_o);
    for (int c = 0; c < 2; c++) begin
      cyc_start();
      req_valid_i = '0; wr_q_ready_i = 1'b0; wr_p_valid_i = 1'b1;
    end
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL lock_idle: got %b want 1", idle_o); end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < MO; k++) begin
      cyc_start();
      req_valid_i = 2'b01; req_addr_i[0] = 16'(16'h0100 + k); wr_q_ready_i = 1'b1;
      #4;
      n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL full_fill[%0d]: got %b want 01", k, req_ready_o); end
      $display("full: accepted addr %h", wr_addr_o);
    end
    cyc_start();
    req_addr_i[0] = 16'h0200;
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b0) begin n_bad++; $display("FAIL full_valid: got %b want 0", wr_q_valid_o); end
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL full_ready: got %b want 00", req_ready_o); end
    cyc_start();
    wr_p_valid_i = 1'b1;
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin n_bad++; $display("FAIL full_ack_cycle: got %b/%b want 0/00", wr_q_valid_o, req_ready_o); end
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b1 || req_ready_o !== 2'b01) begin n_bad++; $display("FAIL full_resume: got %b/%b want 1/01", wr_q_valid_o, req_ready_o); end
    $display("full: resumed with addr %h", wr_addr_o);
    cyc_start();
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b0) begin n_bad++; $display("FAIL full_again: got %b want 0", wr_q_valid_o); end
    for (int c = 0; c < MO; c++) begin
      cyc_start();
      req_valid_i = '0; wr_q_ready_i = 1'b0; wr_p_valid_i = 1'b1;
    end
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL full_drain: got idle=%b err=%b want 1/0", idle_o, err_o); end
  endtask

  task automatic test_simul_accept_ack();
    logic [2:0] exp_hz;
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      cyc_start();
      req_valid_i = 2'b01; req_addr_i[0] = 16'(16'h0300 + k); wr_q_ready_i = 1'b1;
    end
    cyc_start();
    req_addr_i[0] = 16'h0303; wr_p_valid_i = 1'b1;
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b1 || req_ready_o !== 2'b01) begin n_bad++; $display("FAIL simul_accept: got %b/%b want 1/01", wr_q_valid_o, req_ready_o); end
    $display("simul: accepted addr %h with ack", wr_addr_o);
    cyc_start();
    req_valid_i = '0; wr_q_ready_i = 1'b0; wr_p_valid_i = 1'b0;
    chk_addr_i[0] = 16'h0301; chk_addr_i[1] = 16'h0302; chk_addr_i[2] = 16'h0303;
    chk_en_i = 3'b111;
    #4;
    exp_hz = HzEn ? 3'b110 : 3'b000;
    n_cmp++; if (hazard_o !== exp_hz) begin n_bad++; $display("FAIL simul_fifo: got %b want %b", hazard_o, exp_hz); end
    n_cmp++; if (idle_o !== 1'b0) begin n_bad++; $display("FAIL simul_busy: got %b want 0", idle_o); end
    chk_en_i = '0;
    for (int k = 4; k <= 5; k++) begin
      cyc_start();
      req_valid_i = 2'b01; req_addr_i[0] = 16'(16'h0300 + k); wr_q_ready_i = 1'b1;
      #4;
      n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL simul_room[%0d]: got %b want 01", k, req_ready_o); end
    end
    cyc_start();
    req_addr_i[0] = 16'h0306;
    #4;
    n_cmp++; if (wr_q_valid_o !== 1'b0) begin n_bad++; $display("FAIL simul_full: got %b want 0", wr_q_valid_o); end
    for (int c = 0; c < MO; c++) begin
      cyc_start();
      req_valid_i = '0; wr_q_ready_i = 1'b0; wr_p_valid_i = 1'b1;
    end
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL simul_drain: got idle=%b err=%b want 1/0", idle_o, err_o); end
  endtask

  task automatic test_hazard();
    logic [2:0] hz1;
    logic [2:0] hz3;
    hz1 = HzEn ? 3'b010 : 3'b000;
    hz3 = HzEn ? 3'b011 : 3'b000;
    do_reset();
    cyc_start();
    req_valid_i = 2'b01; req_addr_i[0] = 16'h0010; wr_q_ready_i = 1'b0;
    chk_addr_i[0] = 16'h0010; chk_addr_i[1] = 16'h0010; chk_addr_i[2] = 16'h0020;
    chk_en_i = 3'b010;
    #4;
    n_cmp++; if (hazard_o !== hz1) begin n_bad++; $display("FAIL hz_pending: got %b want %b", hazard_o, hz1); end
    cyc_start();
    wr_q_ready_i = 1'b1;
    #4;
    n_cmp++; if (hazard_o !== hz1) begin n_bad++; $display("FAIL hz_accept: got %b want %b", hazard_o, hz1); end
    cyc_start();
    req_valid_i = '0; wr_q_ready_i = 1'b0; chk_en_i = 3'b111;
    #4;
    n_cmp++; if (hazard_o !== hz3) begin n_bad++; $display("FAIL hz_inflight: got %b want %b", hazard_o, hz3); end
    cyc_start();
    chk_en_i = 3'b010; wr_p_valid_i = 1'b1;
    #4;
    n_cmp++; if (hazard_o !== hz1) begin n_bad++; $display("FAIL hz_ack_cycle: got %b want %b", hazard_o, hz1); end
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (hazard_o !== 3'b000) begin n_bad++; $display("FAIL hz_cleared: got %b want 000", hazard_o); end
    $display("hazard: address 0010 tracked through accept and ack");
    chk_en_i = '0;
  endtask

  task automatic test_error_reset();
    do_reset();
    cyc_start();
    wr_p_valid_i = 1'b1;
    #4;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", err_o); end
    for (int c = 0; c < 3; c++) begin
      cyc_start();
      wr_p_valid_i = 1'b0;
      #4;
      n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky[%0d]: got %b want 1", c, err_o); end
    end
    n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL err_cnt_zero: got %b want 1", idle_o); end
    for (int k = 0; k < 3; k++) begin
      cyc_start();
      req_valid_i = 2'b01; req_addr_i[0] = 16'(16'h0400 + k); wr_q_ready_i = 1'b1;
    end
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    req_valid_i = '0; wr_q_ready_i = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_err: got %b want 0", err_o); end
    n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL rst_async_idle: got %b want 1", idle_o); end
    $display("error: async reset mid-burst cleared tracking");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc_start();
    wr_p_valid_i = 1'b1;
    cyc_start();
    wr_p_valid_i = 1'b0;
    #4;
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_after_rst: got %b want 1", err_o); end
  endtask

  task automatic test_random();
    logic [N-1:0] acc = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cyc_start();
      for (int j = 0; j < N; j++) begin
        if (!req_valid_i[j] || acc[j]) begin
          req_valid_i[j] = ($urandom_range(0, 2) != 0);
          req_addr_i[j]  = 16'($urandom_range(0, 7));
          req_data_i[j]  = {$urandom, $urandom};
          req_strb_i[j]  = 8'($urandom);
        end
      end
      wr_q_ready_i = ($urandom_range(0, 3) != 0);
      wr_p_valid_i = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      for (int i = 0; i < 3; i++) chk_addr_i[i] = 16'($urandom_range(0, 7));
      chk_en_i = 3'($urandom);
      #4;
      model_eval();
      n_cmp++; if (wr_q_valid_o !== e_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, wr_q_valid_o, e_valid); end
      n_cmp++; if (req_ready_o !== e_ready) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready_o, e_ready); end
      n_cmp++; if (idle_o !== e_idle) begin n_bad++; $display("FAIL rnd_idle[%0d]: got %b want %b", c, idle_o, e_idle); end
      n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", c, err_o, m_err); end
      n_cmp++; if (hazard_o !== e_hz) begin n_bad++; $display("FAIL rnd_hazard[%0d]: got %b want %b", c, hazard_o, e_hz); end
      if (e_valid) begin
        n_cmp++;
        if (wr_addr_o !== req_addr_i[e_g] || wr_data_o !== req_data_i[e_g] || wr_strb_o !== req_strb_i[e_g]) begin
          n_bad++;
          $display("FAIL rnd_payload[%0d]: got %h/%h/%h want %h/%h/%h", c, wr_addr_o, wr_data_o, wr_strb_o,
                   req_addr_i[e_g], req_data_i[e_g], req_strb_i[e_g]);
        end
      end
      acc = '0;
      if (e_valid && wr_q_ready_i) begin
        acc[e_g] = 1'b1;
        $display("rnd cycle %0d: req%0d write addr %h (in flight %0d)", c, e_g, req_addr_i[e_g], m_q.size());
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_grant_lock();
    test_full_stall();
    test_simul_accept_ack();
    test_hazard();
    test_error_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
